// File: rtl/bfp_align_seq.sv
// Block-floating-point exponent alignment sequencer: buffers a group of exponent beats,
// tracks the group max, then replays per-lane shift amounts. Optional macro: BFP_ALIGN_SAT_EN.
module bfp_align_seq #(
  parameter int unsigned MACRO_DATA_WIDTH = 128,
  parameter int unsigned EXP_WIDTH        = 4,
  parameter int unsigned GROUP_BEATS      = 4,
  parameter int unsigned SHIFT_MAX        = 7
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [EXP_WIDTH*MACRO_DATA_WIDTH-1:0] in_exp,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [EXP_WIDTH*MACRO_DATA_WIDTH-1:0] out_shift,
  output logic                                  out_last,
  output logic [EXP_WIDTH-1:0]                  grp_max_exp,
  output logic                                  busy
);

  localparam int unsigned DataW = EXP_WIDTH * MACRO_DATA_WIDTH;
  localparam int unsigned CntW  = (GROUP_BEATS > 1) ? $clog2(GROUP_BEATS) : 1;
  localparam logic [CntW-1:0]      LastIdx  = CntW'(GROUP_BEATS - 1);
  localparam logic [EXP_WIDTH-1:0] ShiftCap = EXP_WIDTH'(SHIFT_MAX);
`ifdef BFP_ALIGN_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e               state_q, state_d;
  logic [DataW-1:0]     buffer_q [GROUP_BEATS];
  logic [CntW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]      last_idx_q, last_idx_d;
  logic [EXP_WIDTH-1:0] run_max_q, run_max_d;
  logic [EXP_WIDTH-1:0] grp_max_q, grp_max_d;
  logic [EXP_WIDTH-1:0] beat_max, merged_max;
  logic                 in_fire, out_fire, close_grp, first_beat, buf_we;

  assign in_ready    = (state_q != StDrain);
  assign out_valid   = (state_q == StDrain);
  assign busy        = (state_q != StIdle);
  assign grp_max_exp = grp_max_q;
  assign out_last    = (state_q == StDrain) && (rd_cnt_q == last_idx_q);

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign close_grp  = in_fire & (in_last | (wr_cnt_q == LastIdx));
  assign first_beat = (state_q == StIdle) || (wr_cnt_q == '0);

  always_comb begin
    beat_max = '0;
    for (int unsigned i = 0; i < MACRO_DATA_WIDTH; i++) begin
      if (in_exp[i*EXP_WIDTH +: EXP_WIDTH] > beat_max) beat_max = in_exp[i*EXP_WIDTH +: EXP_WIDTH];
    end
  end

  always_comb begin
    if (first_beat || (beat_max > run_max_q)) merged_max = beat_max;
    else                                      merged_max = run_max_q;
  end

  // Group max is never below any buffered exponent, so the subtraction cannot wrap.
  always_comb begin
    logic [DataW-1:0]     cur;
    logic [EXP_WIDTH-1:0] diff;
    out_shift = '0;
    cur       = buffer_q[rd_cnt_q];
    for (int unsigned i = 0; i < MACRO_DATA_WIDTH; i++) begin
      diff = grp_max_q - cur[i*EXP_WIDTH +: EXP_WIDTH];
      if (SatEn && (diff > ShiftCap)) diff = ShiftCap;
      out_shift[i*EXP_WIDTH +: EXP_WIDTH] = diff;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    last_idx_d = last_idx_q;
    run_max_d  = run_max_q;
    grp_max_d  = grp_max_q;
    buf_we     = 1'b0;
    unique case (state_q)
      StIdle, StFill: begin
        if (in_fire) begin
          buf_we    = 1'b1;
          run_max_d = merged_max;
          wr_cnt_d  = wr_cnt_q + 1'b1;
          state_d   = StFill;
          if (close_grp) begin
            state_d    = StDrain;
            grp_max_d  = merged_max;
            last_idx_d = wr_cnt_q;
            rd_cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          if (out_last) begin
            state_d  = StIdle;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      last_idx_q <= '0;
      run_max_q  <= '0;
      grp_max_q  <= '0;
      for (int unsigned b = 0; b < GROUP_BEATS; b++) buffer_q[b] <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      last_idx_q <= last_idx_d;
      run_max_q  <= run_max_d;
      grp_max_q  <= grp_max_d;
      if (buf_we) buffer_q[wr_cnt_q] <= in_exp;
    end
  end

endmodule
